// File: rtl/video_luma_filter.sv
// Rec.709 luma post-processor: RGB -> Y, display-mode map, scanline dimming, frame-latched mode.
// Fixed 3-cycle latency on pixels, hsync, vsync and de; no backpressure (pixel-clock stream).
module video_luma_filter #(
  parameter int CW        = 6,
  parameter int VS_POL    = 0,
  parameter int HS_POL    = 0,
  parameter int DIM_SHIFT = 1
) (
  input  logic          clk_vga,
  input  logic          rst,
  input  logic [CW-1:0] pix_r,
  input  logic [CW-1:0] pix_g,
  input  logic [CW-1:0] pix_b,
  input  logic          hsync_in,
  input  logic          vsync_in,
  input  logic          de_in,
  input  logic [2:0]    mode_req,
  input  logic          scan_req,
  input  logic [CW-1:0] tint_r,
  input  logic [CW-1:0] tint_g,
  input  logic [CW-1:0] tint_b,
  output logic [CW-1:0] vga_r,
  output logic [CW-1:0] vga_g,
  output logic [CW-1:0] vga_b,
  output logic          hsync_out,
  output logic          vsync_out,
  output logic          de_out,
  output logic [2:0]    mode_active
);

  localparam int PW = CW + 8;
  localparam int SW = CW + 10;
  localparam logic VS_ACT = (VS_POL != 0);
  localparam logic HS_ACT = (HS_POL != 0);
  localparam logic [PW-1:0] K_R = PW'(54);
  localparam logic [PW-1:0] K_G = PW'(183);
  localparam logic [PW-1:0] K_B = PW'(18);
  localparam logic [CW-1:0] CMAX = {CW{1'b1}};

  localparam logic [2:0] M_GREEN = 3'd1;
  localparam logic [2:0] M_AMBER = 3'd2;
  localparam logic [2:0] M_WHITE = 3'd3;
  localparam logic [2:0] M_TINT  = 3'd4;
  localparam logic [2:0] M_INV   = 3'd5;

  // ---------------- frame / line control ----------------
  logic       vs_prev_q, hs_prev_q;
  logic       vs_lead, hs_lead;
  logic [2:0] mode_q, mode_d;
  logic       scan_q, scan_d;
  logic       par_q, par_d;

  always_comb begin
    vs_lead = (vsync_in == VS_ACT) && (vs_prev_q != VS_ACT);
    hs_lead = (hsync_in == HS_ACT) && (hs_prev_q != HS_ACT);
    mode_d  = mode_q;
    scan_d  = scan_q;
    par_d   = par_q;
    // A frame start also restarts line parity, overriding a coincident hsync edge.
    if (vs_lead) begin
      mode_d = mode_req;
      scan_d = scan_req;
      par_d  = 1'b0;
    end else if (hs_lead) begin
      par_d  = ~par_q;
    end
  end

  always_ff @(posedge clk_vga) begin
    if (rst) begin
      vs_prev_q <= ~VS_ACT;
      hs_prev_q <= ~HS_ACT;
      mode_q    <= 3'd0;
      scan_q    <= 1'b0;
      par_q     <= 1'b0;
    end else begin
      vs_prev_q <= vsync_in;
      hs_prev_q <= hsync_in;
      mode_q    <= mode_d;
      scan_q    <= scan_d;
      par_q     <= par_d;
    end
  end

  // ---------------- stage 1: weighted products ----------------
  logic [PW-1:0] pr_d, pg_d, pb_d;
  logic [PW-1:0] s1_pr_q, s1_pg_q, s1_pb_q;
  logic [CW-1:0] s1_r_q, s1_g_q, s1_b_q;
  logic          s1_hs_q, s1_vs_q, s1_de_q, s1_par_q;

  assign pr_d = PW'(pix_r) * K_R;
  assign pg_d = PW'(pix_g) * K_G;
  assign pb_d = PW'(pix_b) * K_B;

  always_ff @(posedge clk_vga) begin
    if (rst) begin
      s1_pr_q  <= '0;
      s1_pg_q  <= '0;
      s1_pb_q  <= '0;
      s1_r_q   <= '0;
      s1_g_q   <= '0;
      s1_b_q   <= '0;
      s1_hs_q  <= ~HS_ACT;
      s1_vs_q  <= ~VS_ACT;
      s1_de_q  <= 1'b0;
      s1_par_q <= 1'b0;
    end else begin
      s1_pr_q  <= pr_d;
      s1_pg_q  <= pg_d;
      s1_pb_q  <= pb_d;
      s1_r_q   <= pix_r;
      s1_g_q   <= pix_g;
      s1_b_q   <= pix_b;
      s1_hs_q  <= hsync_in;
      s1_vs_q  <= vsync_in;
      s1_de_q  <= de_in;
      s1_par_q <= par_d;
    end
  end

  // ---------------- stage 2: rounded luma ----------------
  logic [SW-1:0] sum_d, y_full_d;
  logic [CW-1:0] y_d;
  logic [CW-1:0] s2_y_q, s2_r_q, s2_g_q, s2_b_q;
  logic [CW-1:0] s2_tr_q, s2_tg_q, s2_tb_q;
  logic          s2_hs_q, s2_vs_q, s2_de_q, s2_par_q;

  assign sum_d    = SW'(s1_pr_q) + SW'(s1_pg_q) + SW'(s1_pb_q) + SW'(128);
  assign y_full_d = sum_d >> 8;
  assign y_d      = (y_full_d > SW'(CMAX)) ? CMAX : y_full_d[CW-1:0];

  always_ff @(posedge clk_vga) begin
    if (rst) begin
      s2_y_q   <= '0;
      s2_r_q   <= '0;
      s2_g_q   <= '0;
      s2_b_q   <= '0;
      s2_tr_q  <= '0;
      s2_tg_q  <= '0;
      s2_tb_q  <= '0;
      s2_hs_q  <= ~HS_ACT;
      s2_vs_q  <= ~VS_ACT;
      s2_de_q  <= 1'b0;
      s2_par_q <= 1'b0;
    end else begin
      s2_y_q   <= y_d;
      s2_r_q   <= s1_r_q;
      s2_g_q   <= s1_g_q;
      s2_b_q   <= s1_b_q;
      s2_tr_q  <= tint_r;
      s2_tg_q  <= tint_g;
      s2_tb_q  <= tint_b;
      s2_hs_q  <= s1_hs_q;
      s2_vs_q  <= s1_vs_q;
      s2_de_q  <= s1_de_q;
      s2_par_q <= s1_par_q;
    end
  end

  // ---------------- stage 3: mode map, dimming, blanking ----------------
  logic [2*CW-1:0] tp_r, tp_g, tp_b;
  logic [CW-1:0]   m_r, m_g, m_b;
  logic [CW-1:0]   o_r_d, o_g_d, o_b_d;
  logic [CW-1:0]   o_r_q, o_g_q, o_b_q;
  logic            o_hs_q, o_vs_q, o_de_q;

  assign tp_r = (2*CW)'(s2_y_q) * (2*CW)'(s2_tr_q);
  assign tp_g = (2*CW)'(s2_y_q) * (2*CW)'(s2_tg_q);
  assign tp_b = (2*CW)'(s2_y_q) * (2*CW)'(s2_tb_q);

  always_comb begin
    m_r = s2_r_q;
    m_g = s2_g_q;
    m_b = s2_b_q;
    case (mode_q)
      M_GREEN: begin m_r = '0;     m_g = s2_y_q;      m_b = '0;     end
      M_AMBER: begin m_r = s2_y_q; m_g = s2_y_q >> 1; m_b = '0;     end
      M_WHITE: begin m_r = s2_y_q; m_g = s2_y_q;      m_b = s2_y_q; end
      M_TINT: begin
        m_r = tp_r[2*CW-1:CW];
        m_g = tp_g[2*CW-1:CW];
        m_b = tp_b[2*CW-1:CW];
      end
      M_INV: begin
        m_r = CMAX - s2_y_q;
        m_g = CMAX - s2_y_q;
        m_b = CMAX - s2_y_q;
      end
      default: ;
    endcase
    o_r_d = m_r;
    o_g_d = m_g;
    o_b_d = m_b;
    if (scan_q && s2_par_q) begin
      o_r_d = m_r >> DIM_SHIFT;
      o_g_d = m_g >> DIM_SHIFT;
      o_b_d = m_b >> DIM_SHIFT;
    end
    if (!s2_de_q) begin
      o_r_d = '0;
      o_g_d = '0;
      o_b_d = '0;
    end
  end

  always_ff @(posedge clk_vga) begin
    if (rst) begin
      o_r_q  <= '0;
      o_g_q  <= '0;
      o_b_q  <= '0;
      o_hs_q <= ~HS_ACT;
      o_vs_q <= ~VS_ACT;
      o_de_q <= 1'b0;
    end else begin
      o_r_q  <= o_r_d;
      o_g_q  <= o_g_d;
      o_b_q  <= o_b_d;
      o_hs_q <= s2_hs_q;
      o_vs_q <= s2_vs_q;
      o_de_q <= s2_de_q;
    end
  end

  assign vga_r       = o_r_q;
  assign vga_g       = o_g_q;
  assign vga_b       = o_b_q;
  assign hsync_out   = o_hs_q;
  assign vsync_out   = o_vs_q;
  assign de_out      = o_de_q;
  assign mode_active = mode_q;

endmodule
